// File: rtl/writeback_regfile_pkg.sv
// Shared pipeline package: default widths for the pipeline registers and the
// writeback register file.
package writeback_regfile_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_NUM_REGS = 2 ** DEF_ADDR_W;

    // Widths of the other pipeline-register fields carried alongside the data
    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;
    localparam int OPCODE_W = 6;
    localparam int FUNCT_W  = 6;

endpackage

// File: rtl/writeback_regfile_wb.sv
// Writeback data select: load data or ALU result. Also instantiated by the EX
// forwarding path so both sides agree on the selected value.
module wb_mux
    import writeback_regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              mem_to_reg,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] wb_data
);

    assign wb_data = mem_to_reg ? mem_data : alu_result;

endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage plus 2-read/1-write register file with write-to-read bypass
// and a hardwired-zero register 0.
module writeback_regfile
    import writeback_regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [ADDR_W-1:0] reg_dest_in,
    input  logic              MemToReg_in,
    input  logic              RegWrite_in,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] wb_data_out,
    output logic [ADDR_W-1:0] wb_reg_dest_out,
    output logic              wb_write_out
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              rs_bypass;
    logic              rt_bypass;

    wb_mux #(.DATA_W(DATA_W)) u_wb_mux (
        .mem_to_reg (MemToReg_in),
        .mem_data   (mem_data_in),
        .alu_result (alu_result_in),
        .wb_data    (wb_data_out)
    );

    assign wb_reg_dest_out = reg_dest_in;

    // Gating with reset_n drops any write whose edge lands inside reset and
    // disables bypass for the whole reset interval.
    assign wb_write_out = RegWrite_in && (reg_dest_in != '0) && reset_n;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_write_out) begin
            regs[reg_dest_in] <= wb_data_out;
        end
    end

    assign rs_bypass = wb_write_out && (rs_addr == reg_dest_in);
    assign rt_bypass = wb_write_out && (rt_addr == reg_dest_in);

    // regs[0] is never written, but index 0 is forced to zero explicitly so the
    // read path does not depend on that invariant.
    always_comb begin
        rs_data = '0;
        rt_data = '0;
        if (reset_n) begin
            if (rs_bypass)
                rs_data = wb_data_out;
            else if (rs_addr != '0)
                rs_data = regs[rs_addr];
            if (rt_bypass)
                rt_data = wb_data_out;
            else if (rt_addr != '0)
                rt_data = regs[rt_addr];
        end
    end

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: hand-computed expectations checked with
// immediate assertions.
module tb_writeback_regfile;

    logic        clock;
    logic        reset_n;
    logic [31:0] mem_data_in;
    logic [31:0] alu_result_in;
    logic [4:0]  reg_dest_in;
    logic        MemToReg_in;
    logic        RegWrite_in;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] wb_data_out;
    logic [4:0]  wb_reg_dest_out;
    logic        wb_write_out;

    int passed = 0;
    int total  = 0;

    writeback_regfile dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .mem_data_in     (mem_data_in),
        .alu_result_in   (alu_result_in),
        .reg_dest_in     (reg_dest_in),
        .MemToReg_in     (MemToReg_in),
        .RegWrite_in     (RegWrite_in),
        .rs_addr         (rs_addr),
        .rt_addr         (rt_addr),
        .rs_data         (rs_data),
        .rt_data         (rt_data),
        .wb_data_out     (wb_data_out),
        .wb_reg_dest_out (wb_reg_dest_out),
        .wb_write_out    (wb_write_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [4:0] a, input logic [4:0] b);
        rs_addr = a;
        rt_addr = b;
        #1;
    endtask

    initial begin
        reset_n       = 1'b0;
        mem_data_in   = '0;
        alu_result_in = '0;
        reg_dest_in   = 5'd4;
        MemToReg_in   = 1'b0;
        RegWrite_in   = 1'b1;
        rs_addr       = 5'd4;
        rt_addr       = 5'd0;

        // reset state
        #2;
        chk("rst_wb_write", {31'b0, wb_write_out}, 32'h0);
        chk("rst_rs_data", rs_data, 32'h0);
        chk("rst_rt_data", rt_data, 32'h0);
        RegWrite_in = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;

        // ALU write to r7
        @(negedge clock);
        alu_result_in = 32'h1234_5678;
        mem_data_in   = 32'h0BAD_0BAD;
        reg_dest_in   = 5'd7;
        RegWrite_in   = 1'b1;
        rd(5'd7, 5'd1);
        chk("alu_wb_data", wb_data_out, 32'h1234_5678);
        chk("alu_wb_write", {31'b0, wb_write_out}, 32'h1);
        chk("alu_wb_dest", {27'b0, wb_reg_dest_out}, 32'd7);
        chk("alu_rs_bypass", rs_data, 32'h1234_5678);
        chk("alu_rt_nobypass", rt_data, 32'h0);
        @(posedge clock);
        #1 RegWrite_in = 1'b0;
        rd(5'd7, 5'd7);
        chk("alu_r7_after", rs_data, 32'h1234_5678);

        // load with dual bypass on r3
        @(negedge clock);
        MemToReg_in   = 1'b1;
        mem_data_in   = 32'hCAFE_F00D;
        alu_result_in = 32'h1111_2222;
        reg_dest_in   = 5'd3;
        RegWrite_in   = 1'b1;
        rd(5'd3, 5'd3);
        chk("ld_wb_data", wb_data_out, 32'hCAFE_F00D);
        chk("ld_rs_bypass", rs_data, 32'hCAFE_F00D);
        chk("ld_rt_bypass", rt_data, 32'hCAFE_F00D);
        @(posedge clock);
        #1 RegWrite_in = 1'b0;
        rd(5'd3, 5'd7);
        chk("ld_r3_after", rs_data, 32'hCAFE_F00D);
        chk("ld_r7_hold", rt_data, 32'h1234_5678);

        // register zero
        @(negedge clock);
        MemToReg_in   = 1'b0;
        alu_result_in = 32'hFFFF_FFFF;
        reg_dest_in   = 5'd0;
        RegWrite_in   = 1'b1;
        rd(5'd0, 5'd0);
        chk("r0_wb_write", {31'b0, wb_write_out}, 32'h0);
        chk("r0_rs_before", rs_data, 32'h0);
        chk("r0_wb_data", wb_data_out, 32'hFFFF_FFFF);
        @(posedge clock);
        #1 RegWrite_in = 1'b0;
        rd(5'd0, 5'd0);
        chk("r0_rs_after", rs_data, 32'h0);

        // back-to-back writes to r9
        @(negedge clock);
        reg_dest_in   = 5'd9;
        alu_result_in = 32'h1;
        RegWrite_in   = 1'b1;
        @(negedge clock);
        alu_result_in = 32'h2;
        rd(5'd9, 5'd0);
        chk("b2b_r9_first", rt_data, 32'h0);
        chk("b2b_r9_bypass", rs_data, 32'h2);
        @(negedge clock);
        RegWrite_in = 1'b0;
        rd(5'd9, 5'd3);
        chk("b2b_r9_last", rs_data, 32'h2);
        chk("b2b_r3_hold", rt_data, 32'hCAFE_F00D);
        rd(5'd7, 5'd8);
        chk("b2b_r7_hold", rs_data, 32'h1234_5678);
        chk("b2b_r8_hold", rt_data, 32'h0);

        // mid-cycle reset after writing r5
        @(negedge clock);
        alu_result_in = 32'hDEAD_BEEF;
        reg_dest_in   = 5'd5;
        RegWrite_in   = 1'b1;
        @(negedge clock);
        rd(5'd5, 5'd7);
        chk("rstmid_r5_pre", rt_data, 32'h1234_5678);
        RegWrite_in = 1'b0;
        rd(5'd5, 5'd5);
        chk("rstmid_r5_written", rs_data, 32'hDEAD_BEEF);
        RegWrite_in = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        chk("rstmid_r5_zero", rs_data, 32'h0);
        chk("rstmid_wb_write", {31'b0, wb_write_out}, 32'h0);
        @(posedge clock);
        #1;
        chk("rstmid_wb_write_edge", {31'b0, wb_write_out}, 32'h0);
        RegWrite_in = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        rd(5'd5, 5'd7);
        chk("rstmid_r5_released", rs_data, 32'h0);
        chk("rstmid_r7_cleared", rt_data, 32'h0);

        // write across an edge during reset, then first write after release
        @(negedge clock);
        reset_n       = 1'b0;
        alu_result_in = 32'hAA;
        reg_dest_in   = 5'd4;
        RegWrite_in   = 1'b1;
        rd(5'd4, 5'd4);
        chk("rstwr_wb_write", {31'b0, wb_write_out}, 32'h0);
        chk("rstwr_no_bypass", rs_data, 32'h0);
        chk("rstwr_wb_data", wb_data_out, 32'hAA);
        chk("rstwr_wb_dest", {27'b0, wb_reg_dest_out}, 32'd4);
        @(posedge clock);
        #1 RegWrite_in = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        rd(5'd4, 5'd4);
        chk("rstwr_r4_dropped", rs_data, 32'h0);
        reset_n = 1'b0;
        alu_result_in = 32'h55;
        RegWrite_in   = 1'b1;
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1 RegWrite_in = 1'b0;
        rd(5'd4, 5'd4);
        chk("rel_first_write", rt_data, 32'h55);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/writeback_regfile.md
WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 Parameter DATA_W, default 32, data word width of every register and data port.
REQ-002 Parameter ADDR_W, default 5, register address width; the register count is 2**ADDR_W.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 mem_data_in  input  DATA_W  load data from the MEM/WB stage register.
REQ-006 alu_result_in  input  DATA_W  ALU result from the MEM/WB stage register.
REQ-007 reg_dest_in  input  ADDR_W  destination register index from MEM/WB.
REQ-008 MemToReg_in  input  1  1 selects mem_data_in as write data; 0 selects alu_result_in.
REQ-009 RegWrite_in  input  1  write enable from MEM/WB.
REQ-010 rs_addr, rt_addr  input  ADDR_W each  ID-stage read addresses.
REQ-011 rs_data, rt_data  output  DATA_W each  ID-stage read data.
REQ-012 wb_data_out  output  DATA_W  selected writeback data, for the EX forwarding unit.
REQ-013 wb_reg_dest_out  output  ADDR_W  equals reg_dest_in, for the forwarding unit.
REQ-014 wb_write_out  output  1  effective write strobe: RegWrite_in AND reg_dest_in != 0 AND reset_n high.

Function
REQ-015 wb_data_out SHALL be combinational: mem_data_in when MemToReg_in=1, else alu_result_in.
REQ-016 On each rising clock edge with wb_write_out=1, register[reg_dest_in] SHALL take the value of wb_data_out; there is one cycle of write latency.
REQ-017 Register 0 SHALL always read 0; writes to index 0 SHALL be discarded and SHALL NOT be bypassed.
REQ-018 Reads SHALL be combinational with zero latency: rs_data = register[rs_addr], rt_data = register[rt_addr].
REQ-019 Write-read bypass: when wb_write_out=1 and a read address equals reg_dest_in, that port SHALL return wb_data_out in the same cycle.
REQ-020 Both ports SHALL bypass at once when rs_addr = rt_addr = reg_dest_in.
REQ-021 Registers not addressed by a write SHALL hold their value indefinitely.
REQ-022 Writes on back-to-back cycles to the same index: the last write wins; no write is lost or merged.

Reset
REQ-023 While reset_n=0, all registers SHALL be 0 immediately, independent of the clock.
REQ-024 While reset_n=0, rs_data and rt_data SHALL be 0, wb_write_out SHALL be 0, and bypass SHALL be disabled.
REQ-025 wb_data_out and wb_reg_dest_out remain combinational during reset.
REQ-026 A write whose edge coincides with reset_n=0 SHALL be dropped.
REQ-027 The first write after release SHALL occur at the first rising edge sampled with reset_n=1.

Structure
REQ-028 DATA_W, ADDR_W and NUM_REGS defaults SHALL live in the shared pipeline package, together with the other pipeline-register widths.
REQ-029 The writeback data select SHALL be a sub-module, wb_mux, reused by the EX forwarding path.
REQ-030 The register array SHALL be a single 2-read/1-write storage array.
REQ-031 The block SHALL contain no latches and no multi-driven registers.

Verification
REQ-032 Reset: pulse reset_n low mid-cycle after writing 0xDEADBEEF to r5 -> r5 reads 0 immediately; wb_write_out=0 throughout.
REQ-033 ALU write: RegWrite_in=1, MemToReg_in=0, alu_result_in=0x12345678, reg_dest_in=7 -> after the edge, rs_addr=7 reads 0x12345678.
REQ-034 Load plus bypass: MemToReg_in=1, mem_data_in=0xCAFEF00D, reg_dest_in=3, rs_addr=rt_addr=3 in the same cycle -> both ports read 0xCAFEF00D before the edge.
REQ-035 Register zero: write 0xFFFFFFFF to r0 -> wb_write_out=0; rs_addr=0 reads 0 both before and after the edge.
REQ-036 Back-to-back writes to r9: 0x1, then 0x2, then RegWrite_in=0 -> r9 reads 0x2; all other registers unchanged.
REQ-037 Write during reset: reset_n=0 across an edge with RegWrite_in=1, reg_dest_in=4, data 0xAA -> after release, r4 reads 0.
